// File: rtl/md_sched_pkg.sv
// rtl/md_sched_pkg.sv - md op encodings, default latencies and op-class helper
package md_sched_pkg;

   localparam logic [3:0] MD_NONE  = 4'd0;
   localparam logic [3:0] MD_MULT  = 4'd1;
   localparam logic [3:0] MD_MULTU = 4'd2;
   localparam logic [3:0] MD_DIV   = 4'd3;
   localparam logic [3:0] MD_DIVU  = 4'd4;
   localparam logic [3:0] MD_MTHI  = 4'd5;
   localparam logic [3:0] MD_MTLO  = 4'd6;
   localparam logic [3:0] MD_MFHI  = 4'd7;
   localparam logic [3:0] MD_MFLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Ops that occupy the multi-cycle unit (mult/div family)
   function automatic logic is_start_op(input logic [3:0] op);
      return (op >= MD_MULT) && (op <= MD_DIVU);
   endfunction

endpackage

// File: rtl/md_compute.sv
// rtl/md_compute.sv - combinational mult/div datapath producing {hi,lo}
module md_compute
   import md_sched_pkg::*;
(
   input  logic [3:0]  op,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic        div_by_zero
);

   logic [63:0]        prod_s;
   logic [63:0]        prod_u;
   logic signed [31:0] rs_s;
   logic signed [31:0] rt_s;
   logic signed [31:0] quo_s;
   logic signed [31:0] rem_s;
   logic [31:0]        quo_u;
   logic [31:0]        rem_u;
   logic               rt_zero;

   // The low 64 bits of a two's-complement product equal the unsigned
   // product of the sign-extended operands, so both forms use one multiply shape.
   assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
   assign prod_u = {32'd0, rs} * {32'd0, rt};

   assign rs_s    = rs;
   assign rt_s    = rt;
   assign rt_zero = (rt == 32'd0);

   // Zero divisor is steered away so the quotient never becomes undefined.
   assign quo_s = rt_zero ? 32'sd0 : (rs_s / rt_s);
   assign rem_s = rt_zero ? 32'sd0 : (rs_s % rt_s);
   assign quo_u = rt_zero ? 32'd0  : (rs / rt);
   assign rem_u = rt_zero ? 32'd0  : (rs % rt);

   // Select the result pair for the requested op; non-mult/div ops yield zero
   always_comb begin
      hi          = 32'd0;
      lo          = 32'd0;
      div_by_zero = 1'b0;
      case (op)
         MD_MULT:  begin hi = prod_s[63:32]; lo = prod_s[31:0]; end
         MD_MULTU: begin hi = prod_u[63:32]; lo = prod_u[31:0]; end
         MD_DIV:   begin hi = rem_s; lo = quo_s; div_by_zero = rt_zero; end
         MD_DIVU:  begin hi = rem_u; lo = quo_u; div_by_zero = rt_zero; end
         default:  begin hi = 32'd0; lo = 32'd0; end
      endcase
   end

endmodule

// File: rtl/md_sched.sv
// rtl/md_sched.sv - multi-cycle mult/div scheduler owning HI/LO and the md stall request
module md_sched
   import md_sched_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  E_md_op,
   input  logic        E_valid,
   input  logic [31:0] E_rs_data,
   input  logic [31:0] E_rt_data,
   input  logic        D_md_use,
   output logic        md_busy,
   output logic        md_stall,
   output logic [31:0] E_md_result,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   logic [CW-1:0] count;
   logic [CW-1:0] load_val;
   logic [31:0]   pending_hi;
   logic [31:0]   pending_lo;
   logic          pending_ok;
   logic [31:0]   calc_hi;
   logic [31:0]   calc_lo;
   logic          calc_dbz;
   logic          start;
   logic          commit;
   logic          move_ok;

   md_compute u_compute (
      .op          (E_md_op),
      .rs          (E_rs_data),
      .rt          (E_rt_data),
      .hi          (calc_hi),
      .lo          (calc_lo),
      .div_by_zero (calc_dbz)
   );

   assign md_busy  = (count != '0);
   assign start    = E_valid & is_start_op(E_md_op) & ~md_busy;
   assign commit   = (count == CW'(1)) & pending_ok;
   assign move_ok  = E_valid & ~md_busy;
   assign md_stall = D_md_use & (start | md_busy);
   assign load_val = ((E_md_op == MD_MULT) || (E_md_op == MD_MULTU)) ?
                     CW'(MULT_CYCLES) : CW'(DIV_CYCLES);

   // Busy counter: load on start, count down to zero
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (start) begin
         count <= load_val;
      end else if (md_busy) begin
         count <= count - CW'(1);
      end
   end

   // Capture the result at start; a zero divisor marks it as not to be committed
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending_hi <= 32'd0;
         pending_lo <= 32'd0;
         pending_ok <= 1'b0;
      end else if (start) begin
         pending_hi <= calc_hi;
         pending_lo <= calc_lo;
         pending_ok <= ~calc_dbz;
      end
   end

   // HI/LO update: commit on the final busy cycle, or direct moves while idle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         HI <= 32'd0;
         LO <= 32'd0;
      end else if (commit) begin
         HI <= pending_hi;
         LO <= pending_lo;
      end else if (move_ok) begin
         if (E_md_op == MD_MTHI) HI <= E_rs_data;
         if (E_md_op == MD_MTLO) LO <= E_rs_data;
      end
   end

   // Move-from read port seen by the E stage
   always_comb begin
      E_md_result = 32'd0;
      if (E_valid && (E_md_op == MD_MFHI)) E_md_result = HI;
      else if (E_valid && (E_md_op == MD_MFLO)) E_md_result = LO;
   end

endmodule

// File: tb/tb_md_sched.sv
// tb/tb_md_sched.sv - directed self-checking bench for md_sched
module tb_md_sched;

   logic        clk;
   logic        reset;
   logic [3:0]  E_md_op;
   logic        E_valid;
   logic [31:0] E_rs_data;
   logic [31:0] E_rt_data;
   logic        D_md_use;
   logic        md_busy;
   logic        md_stall;
   logic [31:0] E_md_result;
   logic [31:0] HI;
   logic [31:0] LO;

   int total;
   int bad;

   md_sched #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk         (clk),
      .reset       (reset),
      .E_md_op     (E_md_op),
      .E_valid     (E_valid),
      .E_rs_data   (E_rs_data),
      .E_rt_data   (E_rt_data),
      .D_md_use    (D_md_use),
      .md_busy     (md_busy),
      .md_stall    (md_stall),
      .E_md_result (E_md_result),
      .HI          (HI),
      .LO          (LO)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
      E_valid   = v;
      E_md_op   = op;
      E_rs_data = rs;
      E_rt_data = rt;
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      reset = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      D_md_use = 1'b0;
      do_reset();
      total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", md_busy); end
      total++; if (md_stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%0b want=0", md_stall); end
      total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h_%h want=0_0", HI, LO); end
      total++; if (E_md_result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", E_md_result); end
   endtask

   task automatic test_mult();
      int n;
      drive(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3);
      total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL mult_busy_c0 got=%0b want=0", md_busy); end
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n = 0;
      while (md_busy === 1'b1 && n < 50) begin n++; step(); end
      total++; if (n !== 5) begin bad++; $display("FAIL mult_busy_len got=%0d want=5", n); end
      total++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFA) begin
         bad++; $display("FAIL mult_result got=%h_%h want=ffffffff_fffffffa", HI, LO); end
      drive(1'b1, 4'd7, 32'd0, 32'd0);
      total++; if (E_md_result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL mfhi_after_mult got=%h want=ffffffff", E_md_result); end
      drive(1'b1, 4'd8, 32'd0, 32'd0);
      total++; if (E_md_result !== 32'hFFFF_FFFA) begin bad++; $display("FAIL mflo_after_mult got=%h want=fffffffa", E_md_result); end
      drive(1'b0, 4'd8, 32'd0, 32'd0);
      total++; if (E_md_result !== 32'd0) begin bad++; $display("FAIL mflo_bubble got=%h want=0", E_md_result); end
      drive(1'b1, 4'd9, 32'd0, 32'd0);
      total++; if (E_md_result !== 32'd0 || md_stall !== 1'b0) begin
         bad++; $display("FAIL op9_none got=%h/%0b want=0/0", E_md_result, md_stall); end
      step();
      total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL op9_nostart got=%0b want=0", md_busy); end
      drive(1'b0, 4'd0, 32'd0, 32'd0);
   endtask

   task automatic test_multu();
      int n;
      drive(1'b1, 4'd2, 32'hFFFF_FFFF, 32'd2);
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n = 0;
      while (md_busy === 1'b1 && n < 50) begin n++; step(); end
      total++; if (n !== 5) begin bad++; $display("FAIL multu_busy_len got=%0d want=5", n); end
      total++; if (HI !== 32'h0000_0001 || LO !== 32'hFFFF_FFFE) begin
         bad++; $display("FAIL multu_result got=%h_%h want=00000001_fffffffe", HI, LO); end
   endtask

   task automatic test_div_stall();
      int n;
      D_md_use = 1'b1;
      drive(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2);
      total++; if (md_stall !== 1'b1) begin bad++; $display("FAIL div_stall_c0 got=%0b want=1", md_stall); end
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n = 0;
      while (md_stall === 1'b1 && n < 50) begin n++; step(); end
      total++; if (n !== 10) begin bad++; $display("FAIL div_stall_len got=%0d want=10", n); end
      total++; if (md_busy !== 1'b0) begin bad++; $display("FAIL div_busy_c11 got=%0b want=0", md_busy); end
      total++; if (HI !== 32'hFFFF_FFFF || LO !== 32'hFFFF_FFFD) begin
         bad++; $display("FAIL div_result got=%h_%h want=ffffffff_fffffffd", HI, LO); end
      D_md_use = 1'b0;
      #1;
   endtask

   task automatic test_div_by_zero();
      int n;
      do_reset();
      drive(1'b1, 4'd5, 32'h0000_1234, 32'd0);
      step();
      total++; if (HI !== 32'h0000_1234) begin bad++; $display("FAIL mthi got=%h want=00001234", HI); end
      drive(1'b1, 4'd4, 32'd5, 32'd0);
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n = 0;
      while (md_busy === 1'b1 && n < 50) begin n++; step(); end
      total++; if (n !== 10) begin bad++; $display("FAIL divz_busy_len got=%0d want=10", n); end
      total++; if (HI !== 32'h0000_1234 || LO !== 32'd0) begin
         bad++; $display("FAIL divz_hilo got=%h_%h want=00001234_00000000", HI, LO); end
   endtask

   task automatic test_mtlo_while_busy();
      int n;
      drive(1'b1, 4'd1, 32'd3, 32'd4);
      step();
      drive(1'b1, 4'd6, 32'h0000_ABCD, 32'd0);
      step();
      total++; if (LO === 32'h0000_ABCD) begin bad++; $display("FAIL mtlo_busy_ignored got=%h want=not_abcd", LO); end
      drive(1'b1, 4'd3, 32'd100, 32'd7);
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      n = 0;
      while (md_busy === 1'b1 && n < 50) begin n++; step(); end
      total++; if (n !== 3) begin bad++; $display("FAIL mult_rest_len got=%0d want=3", n); end
      total++; if (HI !== 32'd0 || LO !== 32'd12) begin
         bad++; $display("FAIL mtlo_busy_commit got=%h_%h want=00000000_0000000c", HI, LO); end
   endtask

   task automatic test_reset_mid_div();
      drive(1'b1, 4'd4, 32'd20, 32'd3);
      step();
      drive(1'b0, 4'd0, 32'd0, 32'd0);
      step();
      step();
      reset = 1'b1;
      #1;
      total++; if (md_busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         bad++; $display("FAIL reset_mid got=%0b/%h_%h want=0/0_0", md_busy, HI, LO); end
      step();
      reset = 1'b0;
      for (int i = 0; i < 15; i++) step();
      total++; if (md_busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         bad++; $display("FAIL reset_no_commit got=%0b/%h_%h want=0/0_0", md_busy, HI, LO); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      D_md_use = 1'b0;
      E_valid = 1'b0;
      E_md_op = 4'd0;
      E_rs_data = 32'd0;
      E_rt_data = 32'd0;
      test_reset();
      test_mult();
      test_multu();
      test_div_stall();
      test_div_by_zero();
      test_mtlo_while_busy();
      test_reset_mid_div();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
